// File: rtl/fifo_rr_scheduler.sv
// Packet-aware round-robin scheduler: merges several requester FIFOs onto one
// downstream link, holding the winner until its tail flit has been transferred.

module and_or_multiplexer #(
  parameter int INPUTS = 4,
  parameter int WIDTH  = 16
) (
  input  logic [INPUTS-1:0]       sel,
  input  logic [INPUTS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]        data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < INPUTS; i++) begin
      data_out = data_out | (data_in[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
    end
  end

endmodule

module fifo_rr_scheduler #(
  parameter int INPUTS     = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS-1:0]            in_valid,
  input  logic [INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [INPUTS-1:0]            in_last,
  output logic [INPUTS-1:0]            in_pop,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INPUTS-1:0]            grant,
  output logic                         locked
);

  localparam int MW = DATA_WIDTH + 1;

  // Handshake: a flit moves when out_valid & out_ready are both high in the
  // same cycle; that same cycle pops the winning FIFO. out_valid never depends
  // on out_ready, and a locked winner is never replaced while it stalls.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [INPUTS-1:0]   ptr_q, ptr_d;
  logic [INPUTS-1:0]   lock_q, lock_d;
  logic [INPUTS-1:0]   rr_grant;
  logic [INPUTS-1:0]   grant_int;
  logic [INPUTS-1:0]   ptr_adv;
  logic [2*INPUTS-1:0] req_dbl;
  logic [2*INPUTS-1:0] gnt_dbl;
  logic [INPUTS*MW-1:0] mux_in;
  logic [MW-1:0]       mux_out;
  logic                fire;

  // Requests duplicated so the borrow of (req - ptr) finds the first request
  // at or above the pointer, wrapping into the upper copy when needed.
  assign req_dbl  = {in_valid, in_valid};
  assign gnt_dbl  = req_dbl & ~(req_dbl - {{INPUTS{1'b0}}, ptr_q});
  assign rr_grant = gnt_dbl[INPUTS-1:0] | gnt_dbl[2*INPUTS-1:INPUTS];

  assign grant_int = (state_q == LOCKED) ? lock_q : rr_grant;
  assign ptr_adv   = {grant_int[INPUTS-2:0], grant_int[INPUTS-1]};

  for (genvar g = 0; g < INPUTS; g++) begin : g_mux_in
    assign mux_in[g*MW +: MW] = {in_last[g], in_data[g*DATA_WIDTH +: DATA_WIDTH]};
  end

  and_or_multiplexer #(
    .INPUTS (INPUTS),
    .WIDTH  (MW)
  ) u_mux (
    .sel      (grant_int),
    .data_in  (mux_in),
    .data_out (mux_out)
  );

  assign {out_last, out_data} = mux_out;
  assign out_valid = |(grant_int & in_valid);
  assign in_pop    = grant_int & in_valid & {INPUTS{out_ready}};
  assign fire      = out_valid & out_ready;
  assign grant     = grant_int;
  assign locked    = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (fire && !out_last) begin
          state_d = LOCKED;
          lock_d  = grant_int;
        end else if (fire && out_last) begin
          ptr_d = ptr_adv;
        end
      end
      LOCKED: begin
        if (fire && out_last) begin
          state_d = IDLE;
          ptr_d   = ptr_adv;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= {{(INPUTS-1){1'b0}}, 1'b1};
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

`ifndef SYNTHESIS
  a_pop_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_pop))
    else $fatal(1, "in_pop not one-hot");
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_int))
    else $fatal(1, "grant not one-hot");
  a_pop_valid: assert property (@(posedge clk) disable iff (rst) ((in_pop & ~in_valid) == '0))
    else $fatal(1, "pop of an empty FIFO");
  a_no_x: assert property (@(posedge clk) disable iff (rst) !$isunknown({in_valid, out_ready}))
    else $fatal(1, "X on in_valid/out_ready");
`endif

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Packet-aware round-robin scheduler that shares one output channel between INPUTS requester FIFOs (fifo_duth instances) by driving their pop strobes.
- Uses per-input valid, data and last signals. Once a requester wins, it holds the output until its last flit is transferred.
- Sits between the per-source FIFO bank and a single downstream link (router output or AXI channel merge).

Parameters:
- INPUTS, 4, number of requesting FIFOs (>= 2).
- DATA_WIDTH, 16, flit width per input.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  INPUTS  per-FIFO valid (FIFO non-empty).
- in_data  input  INPUTS*DATA_WIDTH  bit-blasted FIFO heads; input i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  INPUTS  head flit of input i is the packet tail.
- in_pop  output  INPUTS  pop strobe to each FIFO.
- out_data  output  DATA_WIDTH  selected flit.
- out_last  output  1  selected tail flag.
- out_valid  output  1  flit offered downstream.
- out_ready  input  1  downstream accepts.
- grant  output  INPUTS  one-hot current/selected winner, zero if none.
- locked  output  1  mid-packet (state LOCKED).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, priority pointer = 1 (input 0 highest), lock grant register = 0. Outputs: in_pop = 0, out_valid = 0, grant = 0, locked = 0. out_data and out_last are don't-care while out_valid = 0.
- State IDLE (combinational arbitration):
  - grant = round-robin pick among in_valid, starting at the pointer position and searching toward higher indices with wrap-around.
  - out_valid = |in_valid.
- State LOCKED:
  - grant = lock register.
  - out_valid = in_valid of the locked input. A bubble is allowed: other inputs are never selected while locked.
- Datapath muxes: out_data and out_last come from an AND-OR mux on grant. Zero-cycle latency from FIFO head to output.
- Pop rule: in_pop[i] = grant[i] & in_valid[i] & out_ready. At most one bit set. A pop never happens when in_valid[i] = 0.
- Transfer: fire = out_valid & out_ready.
- Transitions:
  - IDLE, fire & !out_last: go to LOCKED and latch grant into the lock register.
  - IDLE, fire & out_last: single-flit packet. Stay IDLE and advance the pointer.
  - LOCKED, fire & out_last: go to IDLE and advance the pointer.
  - Otherwise: hold state.
- Pointer advance: pointer = grant rotated left by 1 (wrap from bit INPUTS-1 to bit 0), so the winner becomes lowest priority. The pointer changes only on a tail transfer.
- out_ready low: no pop and no state change. grant and out_data hold stable while the winner's in_valid is held, in both IDLE and LOCKED.
- In IDLE, grant may change while out_ready = 0 if in_valid changes. Downstream must not rely on IDLE-stable grant.
- Reset mid-packet: asynchronous return to IDLE and pointer = 1. The partial packet is abandoned; its upstream is reset together with the scheduler.
- Simulation-only assertions (same style as the FIFO): $onehot0(in_pop), $onehot0(grant), in_pop[i] |-> in_valid[i], no X on in_valid or out_ready. Use $fatal.
- Implementation:
  - RR search as a double-width thermometer/priority scheme.
  - Two-state FSM.
  - Pointer and lock as one-hot registers.
  - Data mux through and_or_multiplexer.

Test Plan:
- Reset, then in_valid = 0000 → out_valid = 0, in_pop = 0000, grant = 0000, locked = 0.
- INPUTS = 4; all inputs hold 1-flit packets (in_last = 1111); out_ready = 1 for 8 cycles → grant sequence 0001, 0010, 0100, 1000, 0001, … with one pop per cycle; out_data matches each input's head.
- Input 1 sends a 3-flit packet, input 0 and input 2 are valid throughout, out_ready = 1 → grant = 0010 for 3 cycles with locked = 1 on cycles 2–3; then grant = 0100 (pointer now at input 2). Input 0 is never popped mid-packet.
- Locked on input 3; in_valid[3] drops for 2 cycles while others are valid → out_valid = 0 and no pops for those 2 cycles. Input 3 resumes and its tail completes → next grant = 0001 (wrap).
- out_ready = 0 for 5 cycles in LOCKED → in_pop = 0000, and grant, out_data and state are unchanged. Release → transfer resumes with the same flit.
- Assert rst while LOCKED on input 2, then deassert with all inputs valid → locked = 0 immediately, and the first grant = 0001.
